cache_line_xfer: RTL and testbench

- Block-transfer engine directly downstream of the cache controller FSM.
- On a miss it moves one whole 32-byte cache line between the cache data SRAM and SDRAM:
  - writeback of a dirty victim line (SRAM to SDRAM),
  - fill of the requested line (SDRAM to SRAM),
  - or both, back to back.
- Owns the SDRAM strobe handshake, SRAM addressing/write-enable and the byte staging register. The controller only issues a request and waits for done.

---
 rtl/cache_line_xfer_pkg.sv | 36 +++
 rtl/cache_line_xfer_line_offset_ctr.sv | 44 ++++
 rtl/cache_line_xfer.sv | 215 +++++++++++++++++++++
 tb/tb_cache_line_xfer.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_line_xfer_pkg.sv
// Shared cache constants, request encodings and the line-transfer state type.
// Used by the cache controller, cache_fsm and the line transfer engine.
package cache_pkg;

  localparam int TAG_SIZE    = 8;
  localparam int INDEX_SIZE  = 3;
  localparam int OFFSET_SIZE = 5;
  localparam int LINE_BYTES  = 1 << OFFSET_SIZE;

  // Request operation: bit 1 = writeback the victim, bit 0 = fill the new line.
  typedef enum logic [1:0] {
    OP_NONE    = 2'b00,
    OP_FILL    = 2'b01,
    OP_WB      = 2'b10,
    OP_WB_FILL = 2'b11
  } req_op_e;

  typedef enum logic [2:0] {
    XFER_IDLE,
    XFER_WB_RD,
    XFER_WB_CAP,
    XFER_WB_STRB,
    XFER_FL_STRB,
    XFER_FL_WR,
    XFER_DONE
  } xfer_state_e;

  function automatic logic op_has_wb(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_has_fill(input logic [1:0] op);
    return op[0];
  endfunction

endpackage

// File: rtl/cache_line_xfer_line_offset_ctr.sv
// Byte offset within a cache line. The owner decides when to clear and when to
// step; the counter never wraps by itself in normal use because the owner
// clears it at the end of each loop instead of incrementing past the last byte.
module line_offset_ctr
  import cache_pkg::*;
#(
  parameter int WIDTH = OFFSET_SIZE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o,
  output logic [WIDTH-1:0] count_next_o,
  output logic             last_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next offset: clear has priority over increment.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  // Offset register, cleared asynchronously with the rest of the engine.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o      = count_q;
  assign count_next_o = count_d;
  assign last_o       = &count_q;

endmodule

// File: rtl/cache_line_xfer.sv
// Moves one 32-byte cache line between the cache data SRAM and SDRAM:
// writeback of a dirty victim, fill of the requested line, or both in turn.
// Every control output is a register; the two data outputs come straight from
// the byte staging register data_q.
module cache_line_xfer
  import cache_pkg::*;
#(
  parameter int ADDR_WIDTH      = TAG_SIZE + INDEX_SIZE + OFFSET_SIZE,
  parameter int ADDR_WIDTH_SRAM = INDEX_SIZE + OFFSET_SIZE,
  parameter int DATA_WIDTH      = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req,
  input  logic [1:0]                 req_op,
  input  logic [INDEX_SIZE-1:0]      req_index,
  input  logic [TAG_SIZE-1:0]        req_wb_tag,
  input  logic [TAG_SIZE-1:0]        req_fill_tag,
  output logic                       busy,
  output logic                       done,
  output logic [ADDR_WIDTH-1:0]      sdram_addr,
  output logic                       sdram_wr_rd,
  output logic                       sdram_mstrb,
  input  logic                       sdram_ack,
  output logic [DATA_WIDTH-1:0]      sdram_din,
  input  logic [DATA_WIDTH-1:0]      sdram_dout,
  output logic [ADDR_WIDTH_SRAM-1:0] sram_addr,
  output logic                       sram_wen,
  output logic [DATA_WIDTH-1:0]      sram_din,
  input  logic [DATA_WIDTH-1:0]      sram_dout
);

  localparam logic [OFFSET_SIZE-1:0] OFFSET_ZERO = '0;

  xfer_state_e                state_q;
  logic                       fill_after_q;
  logic [INDEX_SIZE-1:0]      index_q;
  logic [TAG_SIZE-1:0]        wb_tag_q;
  logic [TAG_SIZE-1:0]        fill_tag_q;
  logic [DATA_WIDTH-1:0]      data_q;

  logic                       busy_q;
  logic                       done_q;
  logic [ADDR_WIDTH-1:0]      sdram_addr_q;
  logic                       sdram_wr_rd_q;
  logic                       sdram_mstrb_q;
  logic [ADDR_WIDTH_SRAM-1:0] sram_addr_q;
  logic                       sram_wen_q;

  logic [OFFSET_SIZE-1:0]     offset_q;
  logic [OFFSET_SIZE-1:0]     offset_d;
  logic                       offset_last;
  logic                       offset_clr;
  logic                       offset_inc;
  logic                       accept;
  logic                       ack_take;

  // A request is only taken while idle and only if it actually asks for work.
  assign accept = (state_q == XFER_IDLE) && req && (req_op != OP_NONE);

  // Ack counts only while our strobe is actually up in a strobe state, so a
  // stray ack at any other time (including the strobe-low gap cycle when the
  // fill follows a writeback) cannot advance the transfer.
  assign ack_take = sdram_mstrb_q && sdram_ack &&
                    ((state_q == XFER_WB_STRB) || (state_q == XFER_FL_STRB));

  // Offset control: clear at acceptance and at the end of the writeback loop,
  // step after each byte that is not the last of the line.
  always_comb begin
    offset_clr = 1'b0;
    offset_inc = 1'b0;
    if (accept) begin
      offset_clr = 1'b1;
    end else if ((state_q == XFER_WB_STRB) && ack_take) begin
      offset_clr = offset_last;
      offset_inc = !offset_last;
    end else if (state_q == XFER_FL_WR) begin
      offset_inc = !offset_last;
    end
  end

  line_offset_ctr #(
    .WIDTH(OFFSET_SIZE)
  ) u_offset (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (offset_clr),
    .inc_i       (offset_inc),
    .count_o     (offset_q),
    .count_next_o(offset_d),
    .last_o      (offset_last)
  );

  // Transfer FSM. Outputs are assigned together with the state they belong to,
  // so each output register already holds the right value during that state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= XFER_IDLE;
      fill_after_q  <= 1'b0;
      index_q       <= '0;
      wb_tag_q      <= '0;
      fill_tag_q    <= '0;
      data_q        <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      sdram_addr_q  <= '0;
      sdram_wr_rd_q <= 1'b0;
      sdram_mstrb_q <= 1'b0;
      sram_addr_q   <= '0;
      sram_wen_q    <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      sram_wen_q <= 1'b0;
      case (state_q)
        XFER_IDLE: begin
          if (accept) begin
            fill_after_q <= op_has_fill(req_op);
            index_q      <= req_index;
            wb_tag_q     <= req_wb_tag;
            fill_tag_q   <= req_fill_tag;
            busy_q       <= 1'b1;
            if (op_has_wb(req_op)) begin
              state_q     <= XFER_WB_RD;
              sram_addr_q <= {req_index, OFFSET_ZERO};
            end else begin
              state_q       <= XFER_FL_STRB;
              sdram_mstrb_q <= 1'b1;
              sdram_wr_rd_q <= 1'b0;
              sdram_addr_q  <= {req_fill_tag, req_index, OFFSET_ZERO};
            end
          end
        end

        // SRAM is sampling sram_addr this cycle; data appears next cycle.
        XFER_WB_RD: begin
          state_q <= XFER_WB_CAP;
        end

        XFER_WB_CAP: begin
          data_q        <= sram_dout;
          state_q       <= XFER_WB_STRB;
          sdram_mstrb_q <= 1'b1;
          sdram_wr_rd_q <= 1'b1;
          sdram_addr_q  <= {wb_tag_q, index_q, offset_q};
        end

        XFER_WB_STRB: begin
          if (ack_take) begin
            sdram_mstrb_q <= 1'b0;
            sdram_wr_rd_q <= 1'b0;
            if (offset_last) begin
              if (fill_after_q) begin
                // Enter the fill with the strobe low for one cycle so the
                // SDRAM sees a clean edge between the two transfers.
                state_q      <= XFER_FL_STRB;
                sdram_addr_q <= {fill_tag_q, index_q, OFFSET_ZERO};
              end else begin
                state_q <= XFER_DONE;
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
              end
            end else begin
              state_q     <= XFER_WB_RD;
              sram_addr_q <= {index_q, offset_d};
            end
          end
        end

        XFER_FL_STRB: begin
          if (!sdram_mstrb_q) begin
            sdram_mstrb_q <= 1'b1;
          end else if (ack_take) begin
            sdram_mstrb_q <= 1'b0;
            data_q        <= sdram_dout;
            state_q       <= XFER_FL_WR;
            sram_wen_q    <= 1'b1;
            sram_addr_q   <= {index_q, offset_q};
          end
        end

        XFER_FL_WR: begin
          if (offset_last) begin
            state_q <= XFER_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            state_q       <= XFER_FL_STRB;
            sdram_mstrb_q <= 1'b1;
            sdram_wr_rd_q <= 1'b0;
            sdram_addr_q  <= {fill_tag_q, index_q, offset_d};
          end
        end

        XFER_DONE: begin
          state_q <= XFER_IDLE;
        end

        default: begin
          state_q <= XFER_IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign sdram_addr  = sdram_addr_q;
  assign sdram_wr_rd = sdram_wr_rd_q;
  assign sdram_mstrb = sdram_mstrb_q;
  assign sdram_din   = data_q;
  assign sram_addr   = sram_addr_q;
  assign sram_wen    = sram_wen_q;
  assign sram_din    = data_q;

endmodule

// File: tb/tb_cache_line_xfer.sv
// Directed bench for cache_line_xfer with a byte SRAM model (registered read)
// and an SDRAM model whose read data equals the low address byte.
module tb_cache_line_xfer;
  import cache_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [1:0]  req_op;
  logic [2:0]  req_index;
  logic [7:0]  req_wb_tag;
  logic [7:0]  req_fill_tag;
  logic        busy;
  logic        done;
  logic [15:0] sdram_addr;
  logic        sdram_wr_rd;
  logic        sdram_mstrb;
  logic        sdram_ack;
  logic [7:0]  sdram_din;
  logic [7:0]  sdram_dout;
  logic [7:0]  sram_addr;
  logic        sram_wen;
  logic [7:0]  sram_din;
  logic [7:0]  sram_dout;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cache_line_xfer dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_op      (req_op),
    .req_index   (req_index),
    .req_wb_tag  (req_wb_tag),
    .req_fill_tag(req_fill_tag),
    .busy        (busy),
    .done        (done),
    .sdram_addr  (sdram_addr),
    .sdram_wr_rd (sdram_wr_rd),
    .sdram_mstrb (sdram_mstrb),
    .sdram_ack   (sdram_ack),
    .sdram_din   (sdram_din),
    .sdram_dout  (sdram_dout),
    .sram_addr   (sram_addr),
    .sram_wen    (sram_wen),
    .sram_din    (sram_din),
    .sram_dout   (sram_dout)
  );

  // SRAM model: synchronous write, registered read, bench-side preload port.
  logic [7:0] mem [0:255];
  logic       pre_we = 1'b0;
  logic [7:0] pre_addr = 8'h00;
  logic [7:0] pre_data = 8'h00;
  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (sram_wen) mem[sram_addr] <= sram_din;
    sram_dout <= mem[sram_addr];
  end

  // SDRAM model: ack after lat_q cycles of strobe, optional stray ack whenever
  // the strobe is low, read data = low address byte.
  int lat_q = 1;
  int cnt_q = 0;
  bit rand_ack = 1'b0;
  bit spur_all = 1'b0;
  assign sdram_ack  = (sdram_mstrb && (cnt_q == lat_q)) || (spur_all && !sdram_mstrb);
  assign sdram_dout = sdram_addr[7:0];
  always @(posedge clk) begin
    if (sdram_mstrb && sdram_ack) begin
      cnt_q <= 0;
      lat_q <= rand_ack ? int'($urandom_range(5, 0)) : 1;
    end else if (sdram_mstrb) begin
      cnt_q <= cnt_q + 1;
    end else begin
      cnt_q <= 0;
      if (!rand_ack) lat_q <= 1;
    end
  end

  // Monitor on the falling edge: log accepted SDRAM beats and SRAM writes,
  // count done pulses and strobe protocol violations.
  logic [24:0] sd_log[$];
  logic [15:0] sram_log[$];
  int          done_cnt = 0;
  int          gap_err = 0;
  int          hold_err = 0;
  int          dir_err = 0;
  bit          taken_prev = 1'b0;
  bit          pend_prev = 1'b0;
  logic [15:0] hold_addr;
  logic        hold_dir;
  logic [7:0]  hold_din;
  always @(negedge clk) begin
    if (rst) begin
      taken_prev = 1'b0;
      pend_prev  = 1'b0;
    end else begin
      if (taken_prev && sdram_mstrb) gap_err++;
      if (pend_prev && sdram_mstrb &&
          ((sdram_addr !== hold_addr) || (sdram_wr_rd !== hold_dir) ||
           (hold_dir && (sdram_din !== hold_din)))) hold_err++;
      if (sdram_wr_rd && !sdram_mstrb) dir_err++;
      if (sdram_wr_rd && sram_wen) dir_err++;
      if (sdram_mstrb && sdram_ack)
        sd_log.push_back({sdram_wr_rd, sdram_addr, sdram_wr_rd ? sdram_din : sdram_dout});
      if (sram_wen) sram_log.push_back({sram_addr, sram_din});
      if (done) done_cnt++;
      taken_prev = sdram_mstrb && sdram_ack;
      pend_prev  = sdram_mstrb && !sdram_ack;
      hold_addr  = sdram_addr;
      hold_dir   = sdram_wr_rd;
      hold_din   = sdram_din;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic start_req(input logic [1:0] op, input logic [2:0] idx,
                           input logic [7:0] wbt, input logic [7:0] flt);
    req = 1'b1; req_op = op; req_index = idx; req_wb_tag = wbt; req_fill_tag = flt;
    tick();
    req = 1'b0; req_op = 2'b00;
  endtask

  // k = number of edges after the accepting edge until done is seen.
  task automatic wait_done(input string tag, input int budget, output int k);
    k = 0;
    while ((done !== 1'b1) && (k < budget)) begin
      tick();
      k++;
    end
    check({tag, "_done_seen"}, 32'(done), 32'd1);
    check({tag, "_busy_low_at_done"}, 32'(busy), 32'd0);
  endtask

  task automatic preload(input logic [7:0] base, input logic [7:0] x);
    for (int i = 0; i < 32; i++) begin
      pre_we = 1'b1; pre_addr = base + 8'(i); pre_data = (base + 8'(i)) ^ x;
      tick();
    end
    pre_we = 1'b0;
  endtask

  task automatic check_sd(input string tag, input int first, input logic wr,
                          input logic [15:0] base, input logic [7:0] x);
    for (int i = 0; i < 32; i++) begin
      logic [15:0] a;
      logic [7:0]  d;
      a = base + 16'(i);
      d = a[7:0] ^ x;
      if (first + i < sd_log.size())
        check(tag, 32'(sd_log[first + i]), 32'({wr, a, d}));
    end
  endtask

  task automatic check_sram(input string tag, input int first, input logic [7:0] base);
    for (int i = 0; i < 32; i++) begin
      logic [7:0] a;
      a = base + 8'(i);
      if (first + i < sram_log.size())
        check(tag, 32'(sram_log[first + i]), 32'({a, a}));
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},        32'(busy),        32'd0);
    check({tag, "_done"},        32'(done),        32'd0);
    check({tag, "_sdram_addr"},  32'(sdram_addr),  32'd0);
    check({tag, "_sdram_wr_rd"}, 32'(sdram_wr_rd), 32'd0);
    check({tag, "_sdram_mstrb"}, 32'(sdram_mstrb), 32'd0);
    check({tag, "_sdram_din"},   32'(sdram_din),   32'd0);
    check({tag, "_sram_addr"},   32'(sram_addr),   32'd0);
    check({tag, "_sram_wen"},    32'(sram_wen),    32'd0);
    check({tag, "_sram_din"},    32'(sram_din),    32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int k;
    int b_sd, b_sr, b_done;

    rst = 1'b0; req = 1'b0; req_op = 2'b00; req_index = '0;
    req_wb_tag = '0; req_fill_tag = '0;
    #1 rst = 1'b1;
    #2 check_all_zero("reset");

    // SRAM contents for the writeback tests, loaded while the DUT is held in reset.
    preload(8'hE0, 8'h00);
    preload(8'h00, 8'h5A);
    preload(8'hA0, 8'h3C);
    rst = 1'b0;
    tick();
    check_all_zero("idle_after_reset");

    // 1: fill, index 3, tag 0x12.
    b_sd = sd_log.size(); b_sr = sram_log.size(); b_done = done_cnt;
    start_req(OP_FILL, 3'd3, 8'h00, 8'h12);
    check("fill_busy", 32'(busy), 32'd1);
    check("fill_first_strobe", 32'(sdram_mstrb), 32'd1);
    check("fill_first_addr", 32'(sdram_addr), 32'h1260);
    wait_done("fill", 300, k);
    check("fill_latency", 32'(k + 1), 32'd97);
    tick();
    check("fill_done_one_cycle", 32'(done), 32'd0);
    repeat (3) tick();
    check("fill_done_count", 32'(done_cnt - b_done), 32'd1);
    check("fill_sdram_beats", 32'(sd_log.size() - b_sd), 32'd32);
    check("fill_sram_writes", 32'(sram_log.size() - b_sr), 32'd32);
    check_sd("fill_beat", b_sd, 1'b0, 16'h1260, 8'h00);
    check_sram("fill_sram", b_sr, 8'h60);

    // 2: writeback, index 7, victim tag 0xAB.
    b_sd = sd_log.size(); b_sr = sram_log.size(); b_done = done_cnt;
    start_req(OP_WB, 3'd7, 8'hAB, 8'h00);
    check("wb_busy", 32'(busy), 32'd1);
    check("wb_first_sram_addr", 32'(sram_addr), 32'hE0);
    check("wb_no_strobe_in_rd", 32'(sdram_mstrb), 32'd0);
    wait_done("wb", 400, k);
    check("wb_latency", 32'(k), 32'd128);
    repeat (3) tick();
    check("wb_done_count", 32'(done_cnt - b_done), 32'd1);
    check("wb_sdram_beats", 32'(sd_log.size() - b_sd), 32'd32);
    check("wb_no_sram_wen", 32'(sram_log.size() - b_sr), 32'd0);
    check_sd("wb_beat", b_sd, 1'b1, 16'hABE0, 8'h00);

    // 3: writeback then fill, index 0, tags 0x01 / 0x02.
    b_sd = sd_log.size(); b_sr = sram_log.size(); b_done = done_cnt;
    start_req(OP_WB_FILL, 3'd0, 8'h01, 8'h02);
    wait_done("wbfill", 600, k);
    check("wbfill_latency", 32'(k), 32'd225);
    check("wbfill_writes_before_done", 32'(sram_log.size() - b_sr), 32'd32);
    repeat (3) tick();
    check("wbfill_done_count", 32'(done_cnt - b_done), 32'd1);
    check("wbfill_sdram_beats", 32'(sd_log.size() - b_sd), 32'd64);
    check_sd("wbfill_wb_beat", b_sd, 1'b1, 16'h0100, 8'h5A);
    check_sd("wbfill_fl_beat", b_sd + 32, 1'b0, 16'h0200, 8'h00);
    check_sram("wbfill_sram", b_sr, 8'h00);

    // 4: random ack latency 0..5 and stray acks whenever the strobe is low.
    rand_ack = 1'b1; spur_all = 1'b1;
    b_sd = sd_log.size(); b_sr = sram_log.size(); b_done = done_cnt;
    repeat (4) tick();
    check("spur_idle_busy", 32'(busy), 32'd0);
    check("spur_idle_beats", 32'(sd_log.size() - b_sd), 32'd0);
    start_req(OP_WB_FILL, 3'd5, 8'h33, 8'h44);
    wait_done("rand", 2000, k);
    spur_all = 1'b0; rand_ack = 1'b0;
    repeat (3) tick();
    check("rand_done_count", 32'(done_cnt - b_done), 32'd1);
    check("rand_sdram_beats", 32'(sd_log.size() - b_sd), 32'd64);
    check("rand_sram_writes", 32'(sram_log.size() - b_sr), 32'd32);
    check_sd("rand_wb_beat", b_sd, 1'b1, 16'h33A0, 8'h3C);
    check_sd("rand_fl_beat", b_sd + 32, 1'b0, 16'h44A0, 8'h00);
    check_sram("rand_sram", b_sr, 8'hA0);
    check("strobe_hold_errors", 32'(hold_err), 32'd0);
    check("strobe_gap_errors", 32'(gap_err), 32'd0);
    check("direction_errors", 32'(dir_err), 32'd0);

    // 5: req pulsed again mid-fill is ignored.
    b_sd = sd_log.size(); b_sr = sram_log.size(); b_done = done_cnt;
    start_req(OP_FILL, 3'd2, 8'h00, 8'h77);
    repeat (40) tick();
    start_req(OP_WB_FILL, 3'd6, 8'h99, 8'h98);
    wait_done("midreq", 300, k);
    check("midreq_latency", 32'(41 + k + 1), 32'd97);
    repeat (3) tick();
    check("midreq_done_count", 32'(done_cnt - b_done), 32'd1);
    check("midreq_sdram_beats", 32'(sd_log.size() - b_sd), 32'd32);
    check_sd("midreq_beat", b_sd, 1'b0, 16'h7740, 8'h00);
    check_sram("midreq_sram", b_sr, 8'h40);

    // op 00 in IDLE is ignored.
    b_sd = sd_log.size(); b_done = done_cnt;
    start_req(OP_NONE, 3'd4, 8'h11, 8'h22);
    check("nop_busy", 32'(busy), 32'd0);
    repeat (5) tick();
    check("nop_busy_later", 32'(busy), 32'd0);
    check("nop_strobe", 32'(sdram_mstrb), 32'd0);
    check("nop_beats", 32'(sd_log.size() - b_sd), 32'd0);
    check("nop_done", 32'(done_cnt - b_done), 32'd0);

    // 6: reset at byte 10 of a fill, then a fresh fill restarts at offset 0.
    b_sd = sd_log.size(); b_sr = sram_log.size(); b_done = done_cnt;
    start_req(OP_FILL, 3'd1, 8'h00, 8'h55);
    k = 0;
    while ((sram_log.size() - b_sr < 10) && (k < 200)) begin tick(); k++; end
    k = 0;
    while ((sdram_mstrb !== 1'b1) && (k < 10)) begin tick(); k++; end
    check("abort_bytes_written", 32'(sram_log.size() - b_sr), 32'd10);
    check("abort_strobing_addr", 32'(sdram_addr), 32'h552A);
    #1 rst = 1'b1;
    #1 check_all_zero("abort");
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("abort_no_done", 32'(done_cnt - b_done), 32'd0);
    b_sd = sd_log.size(); b_done = done_cnt;
    start_req(OP_FILL, 3'd1, 8'h00, 8'h55);
    check("restart_first_addr", 32'(sdram_addr), 32'h5520);
    wait_done("restart", 300, k);
    check("restart_latency", 32'(k + 1), 32'd97);
    repeat (3) tick();
    check("restart_done_count", 32'(done_cnt - b_done), 32'd1);
    check("restart_sdram_beats", 32'(sd_log.size() - b_sd), 32'd32);
    check_sd("restart_beat", b_sd, 1'b0, 16'h5520, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
